rt_cnt_sched: RTL

Round-robin scheduler that shares one external loadable up/down binary counter (32-bit default, sync reset > load > count-enable priority) among NUM_CH timeout requesters. It grants one requester at a time, loads that requester's delay into the counter, decrements to zero, then pulses done to the owner. It sits beside the counter instance and drives all of that counter's control inputs.

---
 rtl/rt_cnt_sched.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/rt_cnt_sched.sv
// rt_cnt_sched: round-robin arbiter that time-shares one external loadable
// down-counter among NUM_CH timeout requesters.
module rt_cnt_sched #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 32
) (
    input  logic                    rt_i_clk,
    input  logic                    rt_i_rst,
    input  logic [NUM_CH-1:0]       rt_i_req,
    input  logic [NUM_CH*CNT_W-1:0] rt_i_dly,
    input  logic [NUM_CH-1:0]       rt_i_cancel,
    output logic [NUM_CH-1:0]       rt_o_gnt,
    output logic                    rt_o_busy,
    output logic [NUM_CH-1:0]       rt_o_done,
    output logic                    rt_o_cnt_rst,
    output logic                    rt_o_cnt_set,
    output logic                    rt_o_cnt_ce,
    output logic                    rt_o_cnt_inc_n,
    output logic [CNT_W-1:0]        rt_o_cnt_ld_val,
    input  logic                    rt_i_cnt_eqnz
);

    localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_DONE
    } state_e;

    state_e            state_q, state_d;
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [NUM_CH-1:0] gnt_q, gnt_d;
    logic [NUM_CH-1:0] done_q, done_d;
    logic [CNT_W-1:0]  dly_q, dly_d;

    logic              found;
    logic [PTR_W-1:0]  win_idx;
    logic [PTR_W-1:0]  cand;
    logic              active;
    logic              cancel_hit;
    logic              abort;

    // First requester at or above the pointer, wrapping past NUM_CH-1.
    always_comb begin
        found   = 1'b0;
        win_idx = '0;
        cand    = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            cand = PTR_W'((int'(ptr_q) + i) % NUM_CH);
            if (!found && rt_i_req[cand]) begin
                found   = 1'b1;
                win_idx = cand;
            end
        end
    end

    assign active     = (state_q == S_LOAD) || (state_q == S_RUN);
    assign cancel_hit = |(rt_i_cancel & gnt_q);
    assign abort      = active && cancel_hit;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        done_d  = '0;
        dly_d   = dly_q;
        unique case (state_q)
            S_IDLE: begin
                if (found) begin
                    gnt_d   = NUM_CH'(1) << win_idx;
                    dly_d   = rt_i_dly[int'(win_idx)*CNT_W +: CNT_W];
                    ptr_d   = (int'(win_idx) == NUM_CH - 1)
                            ? '0 : win_idx + PTR_W'(1);
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (abort) begin
                    gnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (abort) begin
                    gnt_d   = '0;
                    state_d = S_IDLE;
                end else if (!rt_i_cnt_eqnz) begin
                    done_d  = gnt_q;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                gnt_d   = '0;
                state_d = S_IDLE;
            end
            default: begin
                gnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge rt_i_clk) begin
        if (rt_i_rst) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            gnt_q   <= '0;
            done_q  <= '0;
            dly_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            dly_q   <= dly_d;
        end
    end

    // Abort clears the counter, so set/ce are held off in that cycle.
    assign rt_o_gnt        = gnt_q;
    assign rt_o_done       = done_q;
    assign rt_o_busy       = (state_q != S_IDLE);
    assign rt_o_cnt_rst    = rt_i_rst || abort;
    assign rt_o_cnt_set    = (state_q == S_LOAD) && !abort && !rt_i_rst;
    assign rt_o_cnt_ce     = (state_q == S_RUN) && rt_i_cnt_eqnz
                           && !abort && !rt_i_rst;
    assign rt_o_cnt_inc_n  = 1'b1;
    assign rt_o_cnt_ld_val = dly_q;

    a_set_ce_excl: assert property (
        @(posedge rt_i_clk) disable iff (rt_i_rst)
        !(rt_o_cnt_set && rt_o_cnt_ce));

    a_rst_excl: assert property (
        @(posedge rt_i_clk) disable iff (rt_i_rst)
        !(rt_o_cnt_rst && (rt_o_cnt_set || rt_o_cnt_ce)));

    a_gnt_onehot: assert property (
        @(posedge rt_i_clk) disable iff (rt_i_rst)
        $onehot0(rt_o_gnt));

    a_done_owner: assert property (
        @(posedge rt_i_clk) disable iff (rt_i_rst)
        (rt_o_done & ~rt_o_gnt) == '0);

    a_no_dec_zero: assert property (
        @(posedge rt_i_clk) disable iff (rt_i_rst)
        rt_o_cnt_ce |-> rt_i_cnt_eqnz);

endmodule
